// File: rtl/parking_lot_monitor_pkg.sv
// Shared types for the parking-lot monitor: lane FSM states and sensor codes.
// Sensor codes are written as {a,b}, a being the outer sensor.
package parking_pkg;

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} lane_state_t;

  localparam logic [1:0] CLR   = 2'b00;
  localparam logic [1:0] OUTER = 2'b10;
  localparam logic [1:0] BOTH  = 2'b11;
  localparam logic [1:0] INNER = 2'b01;

endpackage

// File: rtl/parking_lot_monitor_if.sv
// Sensor inputs and occupancy/status outputs of the parking-lot monitor.
interface parking_lot_monitor_if #(
  parameter int N_LANES  = 2,
  parameter int CAPACITY = 15
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic [N_LANES-1:0] a;
  logic [N_LANES-1:0] b;
  logic               err_clr;
  logic [N_LANES-1:0] enter;
  logic [N_LANES-1:0] exit;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               underflow;

  modport master (
    output a, b, err_clr,
    input  enter, exit, count, full, empty, overflow, underflow
  );

  modport slave (
    input  a, b, err_clr,
    output enter, exit, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/parking_lot_monitor_lane_fsm.sv
// One lane's entry/exit sequence decoder; events are combinational and
// asserted on the edge that samples CLR from IN3/OUT3.
module lane_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic ent_evt,
  output logic ext_evt
);

  lane_state_t state, state_nxt;
  logic [1:0]  ab;

  assign ab = {a, b};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ab == OUTER) state_nxt = IN1;
            else if (ab == INNER) state_nxt = OUT1;
      IN1:  if (ab == BOTH) state_nxt = IN2;
            else if (ab == CLR) state_nxt = IDLE;
      IN2:  if (ab == INNER) state_nxt = IN3;
            else if (ab == OUTER) state_nxt = IN1;
      IN3:  if (ab == CLR) state_nxt = IDLE;
            else if (ab == BOTH) state_nxt = IN2;
      OUT1: if (ab == BOTH) state_nxt = OUT2;
            else if (ab == CLR) state_nxt = IDLE;
      OUT2: if (ab == OUTER) state_nxt = OUT3;
            else if (ab == INNER) state_nxt = OUT1;
      OUT3: if (ab == CLR) state_nxt = IDLE;
            else if (ab == BOTH) state_nxt = OUT2;
      default: state_nxt = IDLE;
    endcase
  end

  assign ent_evt = (state == IN3)  && (ab == CLR);
  assign ext_evt = (state == OUT3) && (ab == CLR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

endmodule

// File: rtl/parking_lot_monitor.sv
// Multi-lane parking-lot monitor: per-lane entry/exit pulses, saturating
// occupancy count with full/empty and sticky overflow/underflow flags.
module parking_lot_monitor
  import parking_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CAPACITY = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  parking_lot_monitor_if.slave   bus
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  // Kept at least 5 bits so a popcount of up to 8 lanes never wraps.
  localparam int SW    = (CNT_W + 2 > 5) ? CNT_W + 2 : 5;

  logic [N_LANES-1:0] ent_evt, ext_evt;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_fsm u_lane (
      .clk     (clk),
      .reset   (reset),
      .a       (bus.a[i]),
      .b       (bus.b[i]),
      .ent_evt (ent_evt[i]),
      .ext_evt (ext_evt[i])
    );
  end

  logic [3:0]           e_cnt, x_cnt;
  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 ovf_set, udf_set;
  logic [CNT_W-1:0]     cnt_q;

  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < N_LANES; i++) begin
      e_cnt = e_cnt + 4'(ent_evt[i]);
      x_cnt = x_cnt + 4'(ext_evt[i]);
    end
  end

  // Entries and exits net out before saturation is applied.
  always_comb begin
    sum     = $signed(SW'(cnt_q)) + $signed(SW'(e_cnt)) - $signed(SW'(x_cnt));
    ovf_set = 1'b0;
    udf_set = 1'b0;
    cnt_nxt = cnt_q;
    if (sum > $signed(SW'(CAPACITY))) begin
      ovf_set = 1'b1;
      cnt_nxt = CNT_W'(CAPACITY);
    end else if (sum < 0) begin
      udf_set = 1'b1;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = CNT_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      bus.enter     <= '0;
      bus.exit      <= '0;
      bus.full      <= 1'b0;
      bus.empty     <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      cnt_q         <= cnt_nxt;
      bus.enter     <= ent_evt;
      bus.exit      <= ext_evt;
      bus.full      <= (cnt_nxt == CNT_W'(CAPACITY));
      bus.empty     <= (cnt_nxt == '0);
      bus.overflow  <= ovf_set | (bus.overflow  & ~bus.err_clr);
      bus.underflow <= udf_set | (bus.underflow & ~bus.err_clr);
    end
  end

  assign bus.count = cnt_q;

endmodule

// File: doc/parking_lot_monitor.md
Name: parking_lot_monitor

Overview:
Multi-lane parking-lot monitor. Each lane has one photo-sensor pair (a outer, b inner). The block decodes car entries and exits per lane and keeps a saturating occupancy count with full/empty status. It also raises sticky overflow/underflow error flags. It feeds the lot display and gate-control logic and supersedes single-lane detection with lane count, capacity limits and abort/back-up handling.

Parameters:
N_LANES, 2, number of independent sensor-pair lanes (1..8)
CAPACITY, 15, maximum occupancy; count saturates here
CNT_W, $clog2(CAPACITY+1), derived localparam, width of count; not overridable

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clock clk
a  input  N_LANES  outer sensor per lane, 1 = obstructed
b  input  N_LANES  inner sensor per lane, 1 = obstructed
err_clr  input  1  clears overflow/underflow flags
enter  output  N_LANES  per-lane one-cycle pulse, car fully entered
exit  output  N_LANES  per-lane one-cycle pulse, car fully exited
count  output  CNT_W  current occupancy
full  output  1  count == CAPACITY
empty  output  1  count == 0
overflow  output  1  sticky: an entry was refused at CAPACITY
underflow  output  1  sticky: an exit was refused at 0

Behaviour:
- Reset (synchronous): every lane FSM goes to IDLE. enter=0, exit=0, count=0, full=0, empty=1, overflow=0, underflow=0. Reset overrides all other inputs, including mid-sequence lanes.
- Lane FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3. Transitions below are written as {a,b}; any pair not listed means the FSM holds its state.
  - IDLE: 10->IN1; 01->OUT1.
  - IN1: 11->IN2; 00->IDLE (abort, no pulse).
  - IN2: 01->IN3; 10->IN1 (backing up).
  - IN3: 00->IDLE and raise the entry event; 11->IN2 (backing up).
  - OUT1: 11->OUT2; 00->IDLE (abort, no pulse).
  - OUT2: 10->OUT3; 01->OUT1 (backing up).
  - OUT3: 00->IDLE and raise the exit event; 11->OUT2 (backing up).
- Latency: an event is decided at clock edge k, when the FSM samples 00 in IN3 or OUT3.
  - enter[i] or exit[i] is registered and high for exactly the cycle after edge k.
  - count, full, empty and the error flags reflect that event in the same cycle.
  - A lane cannot produce back-to-back pulses, because a new sequence needs at least 4 edges.
- Count update, once per edge:
  - E = popcount of this edge's entry events; X = popcount of exit events.
  - Compute next = count + E − X in a signed width of CNT_W+2 bits.
  - If next > CAPACITY: count=CAPACITY and overflow<=1.
  - If next < 0: count=0 and underflow<=1.
  - Otherwise count=next.
  - Simultaneous entry and exit events net out before saturation. Example: count=CAPACITY with E=1, X=1 gives CAPACITY and no overflow.
- Per-lane enter/exit pulses are always emitted, even when the count saturates.
- full and empty are registered and consistent with count in every cycle.
- err_clr clears both sticky flags at the next edge. If a new violation occurs on the same edge as err_clr, the flag is set (set wins).
- No lane interacts with another lane except through the shared count.

Decomposition:
- Package parking_pkg holds:
  - the lane state enum typedef lane_state_t {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3};
  - localparam constants for the sensor codes (CLR=2'b00, OUTER=2'b10, BOTH=2'b11, INNER=2'b01).
- Sub-module lane_fsm holds one lane: inputs clk, reset, a, b; outputs are single-cycle combinational ent_evt and ext_evt.
- The top level:
  - instantiates N_LANES copies of lane_fsm in a generate loop;
  - registers the pulses;
  - contains the popcount, the saturating counter and the flag logic.

Test Plan:
- N_LANES=2, CAPACITY=15. Lane0 sequence 10,11,01,00, one edge each -> enter[0]=1 for one cycle; count 0->1; empty 1->0; exit=00 throughout.
- Abort on lane0: 10 then 00 -> no enter pulse, count unchanged. Back-up on lane1 exit: 01,11,01,11,10,00 -> exactly one exit[1] pulse at the end.
- count=3. Lane0 entry and lane1 exit both complete on the same edge -> enter=01 and exit=10 in the same cycle; count stays 3; no error flags.
- CAPACITY=3. Four completed entries -> count=3, full=1 after the third. The fourth still pulses enter and sets overflow=1. Pulse err_clr -> overflow=0 next cycle; count stays 3.
- count=0. Lane0 completes an exit -> exit[0] pulses, count stays 0, underflow=1, empty stays 1.
- Drive lane0 to IN2 (10,11), assert reset for one edge, then drive 01,00 -> no enter pulse and count=0, proving the FSM went to IDLE. Then 10,11,01,00 -> a normal enter pulse.
